// File: rtl/otter_fetch_queue.sv
// rtl/otter_fetch_queue.sv - OTTER instruction fetch front end with {pc, ir} FIFO toward decode
module otter_fetch_queue #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        FLUSH,
   input  logic [31:0] FLUSH_PC,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADDR,
   input  logic        IMEM_ACK,
   input  logic [31:0] IMEM_RDATA,
   output logic        IF_VALID,
   output logic [31:0] IF_PC,
   output logic [31:0] IF_IR,
   input  logic        IF_READY
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

   // RUN: nothing in flight; WAIT: read in flight, keep it; DROP: read in flight, discard it
   typedef enum logic [1:0] {RUN, WAIT, DROP} state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   fifo_pc_q [DEPTH];
   logic [31:0]   fifo_ir_q [DEPTH];

   logic          space;
   logic          issue;
   logic          push;
   logic          pop;
   logic [CW:0]   occupancy;
   logic          unused_flush_pc_bits;

   // An in-flight read already owns a slot, so it counts against free space;
   // a same-cycle pop is deliberately not credited to keep the request path short.
   assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, (state_q != RUN)};
   assign space     = (occupancy < DEPTH_C);
   assign issue     = RESET && !FLUSH && space &&
                      ((state_q == RUN) || ((state_q == WAIT) && IMEM_ACK));
   assign push      = (state_q == WAIT) && IMEM_ACK && !FLUSH;
   assign pop       = (count_q != '0) && IF_READY && !FLUSH;

   assign IMEM_REQ  = issue;
   assign IMEM_ADDR = fetch_pc_q;
   assign IF_VALID  = (count_q != '0);
   assign IF_PC     = fifo_pc_q[rd_ptr_q];
   assign IF_IR     = fifo_ir_q[rd_ptr_q];

   // Redirect targets are word aligned; the low bits carry no information
   assign unused_flush_pc_bits = ^FLUSH_PC[1:0];

   // Next-state: flush overrides everything, otherwise issue/accept/pop bookkeeping
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      if (FLUSH) begin
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         fetch_pc_d = {FLUSH_PC[31:2], 2'b00};
         state_d    = ((state_q != RUN) && !IMEM_ACK) ? DROP : RUN;
      end else begin
         if (issue) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            inflight_pc_d = fetch_pc_q;
            state_d       = WAIT;
         end else begin
            case (state_q)
               WAIT:    if (IMEM_ACK) state_d = RUN;
               DROP:    if (IMEM_ACK) state_d = RUN;
               default: state_d = RUN;
            endcase
         end
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control and pointer registers
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q       <= RUN;
         fetch_pc_q    <= RESET_VEC;
         inflight_pc_q <= '0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_pc_q <= inflight_pc_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
      end
   end

   // FIFO storage; cleared on reset so the head reads zero while empty
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            fifo_pc_q[i] <= '0;
            fifo_ir_q[i] <= '0;
         end
      end else if (push) begin
         fifo_pc_q[wr_ptr_q] <= inflight_pc_q;
         fifo_ir_q[wr_ptr_q] <= IMEM_RDATA;
      end
   end

endmodule

// File: tb/tb_otter_fetch_queue.sv
// tb/tb_otter_fetch_queue.sv - directed self-checking bench for otter_fetch_queue
module tb_otter_fetch_queue;

   logic        CLK;
   logic        RESET;
   logic        FLUSH;
   logic [31:0] FLUSH_PC;
   logic        IMEM_REQ;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_ACK;
   logic [31:0] IMEM_RDATA;
   logic        IF_VALID;
   logic [31:0] IF_PC;
   logic [31:0] IF_IR;
   logic        IF_READY;

   int          total = 0;
   int          bad   = 0;
   logic        auto_ack;
   logic        last_req;
   logic [31:0] last_addr;

   otter_fetch_queue #(.DEPTH(4), .RESET_VEC(32'h0000_0000)) dut (
      .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .FLUSH_PC(FLUSH_PC),
      .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK),
      .IMEM_RDATA(IMEM_RDATA), .IF_VALID(IF_VALID), .IF_PC(IF_PC),
      .IF_IR(IF_IR), .IF_READY(IF_READY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // Instruction memory contents: a recognisable word derived from the address
   function automatic logic [31:0] d(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: memory answers a request from the previous cycle when auto_ack is set
   task automatic step();
      last_req  = IMEM_REQ;
      last_addr = IMEM_ADDR;
      @(posedge CLK);
      @(negedge CLK);
      if (auto_ack && last_req) begin
         IMEM_ACK   = 1'b1;
         IMEM_RDATA = d(last_addr);
      end else begin
         IMEM_ACK   = 1'b0;
         IMEM_RDATA = 32'h0;
      end
      #1;
   endtask

   task automatic do_reset(input logic ready);
      @(negedge CLK);
      RESET    = 1'b0;
      FLUSH    = 1'b0;
      IMEM_ACK = 1'b0;
      IF_READY = ready;
      step();
      step();
      @(negedge CLK);
      RESET = 1'b1;
      #1;
   endtask

   initial begin
      RESET      = 1'b0;
      FLUSH      = 1'b0;
      FLUSH_PC   = 32'h0;
      IMEM_ACK   = 1'b0;
      IMEM_RDATA = 32'h0;
      IF_READY   = 1'b1;
      auto_ack   = 1'b1;
      last_req   = 1'b0;
      last_addr  = 32'h0;

      // reset state
      @(negedge CLK);
      @(negedge CLK);
      #1;
      chk("rst_req",   {31'b0, IMEM_REQ}, 32'd0);
      chk("rst_valid", {31'b0, IF_VALID}, 32'd0);
      chk("rst_pc",    IF_PC, 32'h0);
      chk("rst_ir",    IF_IR, 32'h0);

      // streaming fetch, one instruction per cycle
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      chk("t1_req0",  {31'b0, IMEM_REQ}, 32'd1);
      chk("t1_addr0", IMEM_ADDR, 32'h0);
      step();
      chk("t1_addr1",  IMEM_ADDR, 32'h4);
      chk("t1_valid1", {31'b0, IF_VALID}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t1_valid", {31'b0, IF_VALID}, 32'd1);
         chk("t1_pc",    IF_PC, 32'(4 * k));
         chk("t1_ir",    IF_IR, d(32'(4 * k)));
         chk("t1_addr",  IMEM_ADDR, 32'(4 * (k + 2)));
      end

      // decode stalled: exactly four reads, then requests stop
      do_reset(1'b0);
      for (int i = 1; i <= 10; i++) begin
         step();
         chk("t2_req", {31'b0, IMEM_REQ}, (i <= 3) ? 32'd1 : 32'd0);
         if (i <= 3) chk("t2_addr", IMEM_ADDR, 32'(4 * i));
      end
      chk("t2_head", IF_PC, 32'h0);
      IF_READY = 1'b1;
      #1;
      chk("t2_req_held", {31'b0, IMEM_REQ}, 32'd0);
      for (int j = 1; j <= 4; j++) begin
         step();
         chk("t2_drain_pc", IF_PC, 32'(4 * j));
         chk("t2_drain_ir", IF_IR, d(32'(4 * j)));
         if (j == 1) begin
            chk("t2_resume_req",  {31'b0, IMEM_REQ}, 32'd1);
            chk("t2_resume_addr", IMEM_ADDR, 32'h10);
         end
      end

      // flush with the read to 0x8 in flight; its ack arrives the next cycle
      do_reset(1'b1);
      step();
      step();
      chk("t3_addr8", IMEM_ADDR, 32'h8);
      auto_ack = 1'b0;
      step();
      FLUSH    = 1'b1;
      FLUSH_PC = 32'h100;
      #1;
      chk("t3_req_flush", {31'b0, IMEM_REQ}, 32'd0);
      chk("t3_head",      IF_PC, 32'h4);
      step();
      FLUSH      = 1'b0;
      IMEM_ACK   = 1'b1;
      IMEM_RDATA = d(32'h8);
      #1;
      chk("t3_valid_after", {31'b0, IF_VALID}, 32'd0);
      chk("t3_req_drop",    {31'b0, IMEM_REQ}, 32'd0);
      step();
      chk("t3_req_redir",  {31'b0, IMEM_REQ}, 32'd1);
      chk("t3_addr_redir", IMEM_ADDR, 32'h100);
      chk("t3_no_push",    {31'b0, IF_VALID}, 32'd0);
      auto_ack = 1'b1;
      step();
      step();
      chk("t3_valid", {31'b0, IF_VALID}, 32'd1);
      chk("t3_pc",    IF_PC, 32'h100);
      chk("t3_ir",    IF_IR, d(32'h100));

      // flush while full and decode ready in the same cycle
      do_reset(1'b0);
      for (int i = 0; i < 5; i++) step();
      IF_READY = 1'b1;
      FLUSH    = 1'b1;
      FLUSH_PC = 32'h40;
      #1;
      chk("t4_full_valid", {31'b0, IF_VALID}, 32'd1);
      chk("t4_req_flush",  {31'b0, IMEM_REQ}, 32'd0);
      step();
      FLUSH = 1'b0;
      #1;
      chk("t4_valid_after", {31'b0, IF_VALID}, 32'd0);
      chk("t4_addr",        IMEM_ADDR, 32'h40);
      step();
      step();
      chk("t4_pc", IF_PC, 32'h40);

      // unaligned redirect and PC wrap at the top of the address space
      FLUSH    = 1'b1;
      FLUSH_PC = 32'hFFFF_FFFF;
      #1;
      step();
      FLUSH = 1'b0;
      #1;
      chk("t5_valid", {31'b0, IF_VALID}, 32'd0);
      chk("t5_top",   IMEM_ADDR, 32'hFFFF_FFFC);
      step();
      chk("t5_wrap_req", {31'b0, IMEM_REQ}, 32'd1);
      chk("t5_wrap",     IMEM_ADDR, 32'h0);
      FLUSH    = 1'b1;
      FLUSH_PC = 32'h203;
      #1;
      step();
      FLUSH = 1'b0;
      #1;
      chk("t5_align", IMEM_ADDR, 32'h200);
      chk("t5_valid2", {31'b0, IF_VALID}, 32'd0);
      step();
      step();
      chk("t5_pc", IF_PC, 32'h200);
      chk("t5_ir", IF_IR, d(32'h200));

      // stray ack with nothing in flight, then reset in the middle of a read
      auto_ack = 1'b0;
      do_reset(1'b1);
      IMEM_ACK   = 1'b1;
      IMEM_RDATA = 32'hBAD0_BAD0;
      #1;
      chk("t6_req", {31'b0, IMEM_REQ}, 32'd1);
      step();
      chk("t6_stray", {31'b0, IF_VALID}, 32'd0);
      RESET = 1'b0;
      #1;
      chk("t6_rst_valid", {31'b0, IF_VALID}, 32'd0);
      chk("t6_rst_req",   {31'b0, IMEM_REQ}, 32'd0);
      step();
      RESET      = 1'b1;
      IMEM_ACK   = 1'b1;
      IMEM_RDATA = 32'hDEAD_BEEF;
      #1;
      chk("t6_vec_req",  {31'b0, IMEM_REQ}, 32'd1);
      chk("t6_vec_addr", IMEM_ADDR, 32'h0);
      step();
      chk("t6_late_ack", {31'b0, IF_VALID}, 32'd0);
      IMEM_ACK   = 1'b1;
      IMEM_RDATA = d(32'h0);
      #1;
      step();
      chk("t6_valid", {31'b0, IF_VALID}, 32'd1);
      chk("t6_pc",    IF_PC, 32'h0);
      chk("t6_ir",    IF_IR, d(32'h0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
